// File: rtl/Pu_inst.sv
// Shared permute-unit instruction types; the fxv predicate condition is used by the
// vector load/store sequencer.
package Pu_inst;

    localparam int unsigned FXV_COND_W = 2;

    typedef enum logic [FXV_COND_W-1:0] {
        FXV_COND_EQ     = 2'd0,
        FXV_COND_LT     = 2'd1,
        FXV_COND_GT     = 2'd2,
        FXV_COND_ALWAYS = 2'd3
    } fxv_cond_t;

endpackage

// File: rtl/Vector_pls_seq_pkg.sv
// Types and sizing helpers for the vector permute/load-store sequencer.
package Vector_pls_seq_pkg;

    localparam int unsigned DEF_NUM_ELEMS = 8;
    localparam int unsigned DEF_ELEM_SIZE = 16;
    localparam int unsigned VREG_IDX_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_WB      = 2'd3
    } seq_state_t;

    // Vector size in bytes (VB); alignment granule for every access.
    function automatic int unsigned vec_bytes(input int unsigned num_elems,
                                              input int unsigned elem_size);
        return (num_elems * elem_size) / 8;
    endfunction

    // Low-bit mask that must be zero in an aligned byte address (valid when VB is a power of two).
    function automatic int unsigned align_mask(input int unsigned vb);
        return vb - 1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/vector_pls_seq_if.sv
// Operation, permute-unit, memory and write-back signals of the vector load/store sequencer.
interface vector_pls_seq_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    import Pu_inst::*;
    import Vector_pls_seq_pkg::*;

    logic                  op_valid;
    logic                  op_ready;
    logic                  op_store;
    fxv_cond_t             op_cond;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [VREG_IDX_W-1:0] op_vt;

    logic                  pls_capture;
    fxv_cond_t             pls_cond;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;

    logic                  wb_valid;
    logic [VREG_IDX_W-1:0] wb_reg;

    logic                  done;
    logic                  err;
    logic                  busy;

    modport master (
        output op_valid, op_store, op_cond, op_addr, op_vt, mem_ack,
        input  op_ready, pls_capture, pls_cond, mem_req, mem_we, mem_addr,
               wb_valid, wb_reg, done, err, busy
    );

    modport slave (
        input  op_valid, op_store, op_cond, op_addr, op_vt, mem_ack,
        output op_ready, pls_capture, pls_cond, mem_req, mem_we, mem_addr,
               wb_valid, wb_reg, done, err, busy
    );

endinterface

// File: rtl/vector_pls_seq.sv
// Vector load/store sequencer: latches an operation, strobes the permute unit's compare
// capture, runs one memory access with a saturating timeout, and writes back load results.
module vector_pls_seq
    import Pu_inst::*;
    import Vector_pls_seq_pkg::*;
#(
    parameter int unsigned NUM_ELEMS  = DEF_NUM_ELEMS,
    parameter int unsigned ELEM_SIZE  = DEF_ELEM_SIZE,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset,
    vector_pls_seq_if.slave  bus
);

    localparam int unsigned VB         = vec_bytes(NUM_ELEMS, ELEM_SIZE);
    localparam bit          VB_POW2    = is_pow2(VB);
    localparam int unsigned CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(align_mask(VB));
    localparam logic [ADDR_WIDTH-1:0] VB_A       = ADDR_WIDTH'(VB);

    seq_state_t             state_q, state_d;
    logic                   store_q, store_d;
    fxv_cond_t              cond_q, cond_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [VREG_IDX_W-1:0]  vt_q, vt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   pls_capture_q, pls_capture_d;
    fxv_cond_t              pls_cond_q, pls_cond_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [VREG_IDX_W-1:0]  wb_reg_q, wb_reg_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    logic                   misaligned_c;

    assign misaligned_c = VB_POW2 ? (|(bus.op_addr & ALIGN_MASK))
                                  : ((bus.op_addr % VB_A) != '0);

    // Next state, operation latch, timeout counter and next registered outputs.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        cond_d      = cond_q;
        addr_d      = addr_q;
        vt_d        = vt_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wb_valid_d  = 1'b0;
        wb_reg_d    = '0;
        pls_capture_d = 1'b0;
        pls_cond_d  = FXV_COND_ALWAYS;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        busy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.op_valid) begin
                    store_d = bus.op_store;
                    cond_d  = bus.op_cond;
                    addr_d  = bus.op_addr;
                    vt_d    = bus.op_vt;
                    if (misaligned_c) err_d   = 1'b1;
                    else              state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A completing ack wins over a timeout expiring in the same cycle.
                if (bus.mem_ack) begin
                    state_d = store_q ? ST_IDLE : ST_WB;
                    done_d  = store_q;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q >= CNT_LAST) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_WB: begin
                state_d    = ST_IDLE;
                done_d     = 1'b1;
                wb_valid_d = 1'b1;
                wb_reg_d   = vt_q;
            end
            default: state_d = ST_IDLE;
        endcase

        pls_capture_d = (state_d == ST_CAPTURE);
        mem_req_d     = (state_d == ST_ACCESS);
        mem_we_d      = mem_req_d & store_d;
        mem_addr_d    = mem_req_d ? addr_d : '0;
        busy_d        = (state_d != ST_IDLE);
        if ((state_d == ST_CAPTURE) || (state_d == ST_ACCESS)) pls_cond_d = cond_d;
    end

    // State, latch and output registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            store_q       <= 1'b0;
            cond_q        <= FXV_COND_ALWAYS;
            addr_q        <= '0;
            vt_q          <= '0;
            cnt_q         <= '0;
            pls_capture_q <= 1'b0;
            pls_cond_q    <= FXV_COND_ALWAYS;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_reg_q      <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            cond_q        <= cond_d;
            addr_q        <= addr_d;
            vt_q          <= vt_d;
            cnt_q         <= cnt_d;
            pls_capture_q <= pls_capture_d;
            pls_cond_q    <= pls_cond_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            wb_valid_q    <= wb_valid_d;
            wb_reg_q      <= wb_reg_d;
            done_q        <= done_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    // Ready is the only output decoded directly; it stays low while reset is held.
    assign bus.op_ready    = (state_q == ST_IDLE) && !reset;
    assign bus.pls_capture = pls_capture_q;
    assign bus.pls_cond    = pls_cond_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_reg      = wb_reg_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vector_pls_seq.sv
// Randomized self-checking bench for vector_pls_seq with an operation-level timeline model.
module tb_vector_pls_seq;
    import Pu_inst::*;

    localparam int TO = 4;
    localparam int VB = 8 * 16 / 8;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    vector_pls_seq_if #(.ADDR_WIDTH(32)) bus ();

    vector_pls_seq #(
        .NUM_ELEMS (8),
        .ELEM_SIZE (16),
        .ADDR_WIDTH(32),
        .TIMEOUT   (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic randomize_op_fields();
        bus.op_store = 1'($urandom_range(0, 1));
        bus.op_cond  = fxv_cond_t'($urandom_range(0, 3));
        bus.op_addr  = $urandom;
        bus.op_vt    = 5'($urandom);
    endtask

    // Idle cycles with mem_ack held high: nothing may start or complete.
    task automatic idle_cycles(input int n);
        bus.op_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.mem_ack = 1'b1;
            @(posedge clk); #1;
            check_val("idle_busy", bus.busy, 0);
            check_val("idle_req", bus.mem_req, 0);
            check_val("idle_done", bus.done, 0);
            check_val("idle_err", bus.err, 0);
            check_val("idle_ready", bus.op_ready, 1);
        end
        bus.mem_ack = 1'b0;
    endtask

    // Offer one op now (sequencer idle) and check every cycle until it completes.
    // d = ACCESS cycles before the ack cycle; d >= TO means the ack never comes.
    task automatic run_op(input logic st, input fxv_cond_t cd, input logic [31:0] ad,
                          input logic [4:0] vt, input int d, input bit hold);
        bit mis;
        bit expired;
        int len;
        int last_acc;
        bit in_acc;
        mis      = (ad % VB) != 0;
        expired  = (d >= TO);
        last_acc = expired ? TO + 1 : 2 + d;
        if (mis)          len = 1;
        else if (expired) len = TO + 2;
        else              len = st ? d + 3 : d + 4;

        check_val("accept_ready", bus.op_ready, 1);
        bus.op_valid = 1'b1;
        bus.op_store = st;
        bus.op_cond  = cd;
        bus.op_addr  = ad;
        bus.op_vt    = vt;
        bus.mem_ack  = 1'($urandom_range(0, 1));

        for (int t = 1; t <= len; t++) begin
            @(posedge clk); #1;
            in_acc = !mis && (t >= 2) && (t <= last_acc);
            check_val("pls_capture", bus.pls_capture, (!mis && t == 1) ? 1 : 0);
            check_val("pls_cond", bus.pls_cond,
                      ((!mis && t == 1) || in_acc) ? cd : FXV_COND_ALWAYS);
            check_val("mem_req", bus.mem_req, in_acc ? 1 : 0);
            if (in_acc) begin
                check_val("mem_we", bus.mem_we, st);
                check_val("mem_addr", bus.mem_addr, ad);
            end
            check_val("done", bus.done, (!mis && !expired && t == len) ? 1 : 0);
            check_val("err", bus.err, ((mis || expired) && t == len) ? 1 : 0);
            check_val("wb_valid", bus.wb_valid, (!mis && !expired && !st && t == len) ? 1 : 0);
            if (!mis && !expired && !st && t == len) check_val("wb_reg", bus.wb_reg, vt);
            check_val("busy", bus.busy, (t < len) ? 1 : 0);
            check_val("op_ready", bus.op_ready, (t == len) ? 1 : 0);

            if (in_acc) bus.mem_ack = !expired && (t == 2 + d);
            else        bus.mem_ack = 1'($urandom_range(0, 1));
            if (t < len) begin
                randomize_op_fields();
                bus.op_valid = hold;
            end
        end
    endtask

    // Reset in the second ACCESS cycle, together with a mem_ack, aborts silently.
    task automatic reset_in_access();
        check_val("rst_accept_ready", bus.op_ready, 1);
        bus.op_valid = 1'b1;
        bus.op_store = 1'b1;
        bus.op_cond  = FXV_COND_LT;
        bus.op_addr  = 32'h80;
        bus.op_vt    = 5'd3;
        bus.mem_ack  = 1'b0;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        @(posedge clk); #1;
        check_val("rst_acc1_req", bus.mem_req, 1);
        @(posedge clk); #1;
        check_val("rst_acc2_req", bus.mem_req, 1);
        reset       = 1'b1;
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        check_val("rst_abort_req", bus.mem_req, 0);
        check_val("rst_abort_done", bus.done, 0);
        check_val("rst_abort_err", bus.err, 0);
        check_val("rst_abort_busy", bus.busy, 0);
        reset       = 1'b0;
        bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        check_val("rst_rel_ready", bus.op_ready, 1);
        check_val("rst_rel_done", bus.done, 0);
        check_val("rst_rel_err", bus.err, 0);
        check_val("rst_rel_req", bus.mem_req, 0);
    endtask

    initial begin
        logic        st;
        fxv_cond_t   cd;
        logic [31:0] ad;
        logic [4:0]  vt;
        bit          hold;
        n_vec  = 0;
        n_miss = 0;

        // Reset with an op and an ack offered: reset must win.
        reset        = 1'b1;
        bus.op_valid = 1'b1;
        bus.op_store = 1'b1;
        bus.op_cond  = FXV_COND_EQ;
        bus.op_addr  = 32'h0;
        bus.op_vt    = 5'd1;
        bus.mem_ack  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pls_capture", bus.pls_capture, 0);
        check_val("rst_pls_cond", bus.pls_cond, FXV_COND_ALWAYS);
        check_val("rst_mem_req", bus.mem_req, 0);
        check_val("rst_mem_we", bus.mem_we, 0);
        check_val("rst_mem_addr", bus.mem_addr, 0);
        check_val("rst_wb_valid", bus.wb_valid, 0);
        check_val("rst_wb_reg", bus.wb_reg, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_err", bus.err, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_op_ready", bus.op_ready, 0);
        bus.op_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        reset        = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_ready", bus.op_ready, 1);
        check_val("post_rst_busy", bus.busy, 0);

        // Directed cases.
        run_op(1'b1, FXV_COND_EQ, 32'h100, 5'd3, 2, 1'b0);
        idle_cycles(1);
        run_op(1'b0, FXV_COND_LT, 32'h40, 5'd7, 0, 1'b0);
        idle_cycles(1);
        run_op(1'b0, FXV_COND_GT, 32'h104, 5'd9, 0, 1'b0);
        idle_cycles(1);
        run_op(1'b1, FXV_COND_GT, 32'h200, 5'd2, 99, 1'b0);
        idle_cycles(1);
        run_op(1'b0, FXV_COND_LT, 32'h220, 5'd6, TO - 1, 1'b0);
        idle_cycles(1);

        // Back-to-back with op_valid held and garbage fields while busy.
        run_op(1'b1, FXV_COND_EQ, 32'h300, 5'd1, 0, 1'b1);
        run_op(1'b0, FXV_COND_LT, 32'h310, 5'd4, 1, 1'b1);
        run_op(1'b1, FXV_COND_ALWAYS, 32'h320, 5'd5, 3, 1'b0);
        idle_cycles(2);

        reset_in_access();

        // Randomized ops.
        for (int i = 0; i < 150; i++) begin
            st = 1'($urandom_range(0, 1));
            cd = fxv_cond_t'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) ad[3:0] = 4'h0;
            vt   = 5'($urandom);
            hold = 1'($urandom_range(0, 1));
            run_op(st, cd, ad, vt, int'($urandom_range(0, 6)), hold);
            if (!hold || ($urandom_range(0, 1) == 0)) idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
